// File: rtl/eq_pkg.sv
// Shared audio-path types and defaults for the equalizer output stage.
package eq_pkg;

    localparam int AUDIO_SAMPLE_W     = 16;
    localparam int I2S_SLOT_W_DEFAULT = 32;

    typedef logic signed [AUDIO_SAMPLE_W-1:0] audio_sample_t;

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample handshake between the equalizer (master) and the I2S transmitter (slave).
interface i2s_transmitter_if
    import eq_pkg::*;
#(
    parameter int SAMPLE_W = AUDIO_SAMPLE_W
);

    logic signed [SAMPLE_W-1:0] in_sample;
    logic                       in_valid;
    logic                       in_ready;

    modport master (
        output in_sample,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_sample,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/i2s_clk_gen.sv
// Purpose: divides clk into the I2S bit clock and flags each BCLK falling edge.
// Latency: i2s_bclk toggles on the edge ending each CLK_DIV-cycle half period.
// Backpressure: none; free-running while reset is high.
module i2s_clk_gen
    import eq_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic i2s_bclk,
    output logic bclk_fall
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;

    assign div_wrap = (div_cnt == DIV_W'(CLK_DIV - 1));
    // High on the cycle whose closing edge drives BCLK 1->0.
    assign bclk_fall = div_wrap && i2s_bclk;

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (div_wrap) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
        end else begin
            div_cnt  <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// Purpose: serialises one buffered mono sample into both I2S slots of a frame
//   (define I2S_LEFT_JUSTIFIED_EN for left-justified instead of one-bit-delay I2S).
// Latency: a sample accepted before a frame start goes out in that frame.
// Backpressure: one-deep holding register; in_ready low while it is full.
module i2s_transmitter
    import eq_pkg::*;
#(
    parameter int SAMPLE_W = AUDIO_SAMPLE_W,
    parameter int SLOT_W   = I2S_SLOT_W_DEFAULT,
    parameter int CLK_DIV  = 4
) (
    input  logic              clk,
    input  logic              reset,
    i2s_transmitter_if.slave  in_if,
    output logic              i2s_bclk,
    output logic              i2s_lrclk,
    output logic              i2s_sdata,
    output logic              underrun
);

    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    logic                       bclk_fall;
    logic [CNT_W-1:0]           bit_cnt;
    logic [CNT_W-1:0]           bit_cnt_nxt;
    logic signed [SAMPLE_W-1:0] hold_q;
    logic signed [SAMPLE_W-1:0] frame_q;
    logic signed [SAMPLE_W-1:0] frame_nxt;
    logic                       ready_q;
    logic                       hold_full;
    logic                       hold_full_nxt;
    logic                       accept;
    logic                       frame_start;

    i2s_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .reset     (reset),
        .i2s_bclk  (i2s_bclk),
        .bclk_fall (bclk_fall)
    );

    // Serial bit for position cnt within the frame; both slots map identically.
    function automatic logic slot_bit(input logic [SAMPLE_W-1:0] word,
                                      input logic [CNT_W-1:0]    cnt);
        int                  p;
        logic [SAMPLE_W-1:0] sh;
        p        = (int'(cnt) >= SLOT_W) ? int'(cnt) - SLOT_W : int'(cnt);
        sh       = '0;
        slot_bit = 1'b0;
`ifdef I2S_LEFT_JUSTIFIED_EN
        if (p < SAMPLE_W) begin
            sh       = word << p;
            slot_bit = sh[SAMPLE_W-1];
        end
`else
        if (p >= 1 && p <= SAMPLE_W) begin
            sh       = word << (p - 1);
            slot_bit = sh[SAMPLE_W-1];
        end
`endif
    endfunction

    assign hold_full      = !ready_q;
    assign in_if.in_ready = ready_q;
    assign accept         = in_if.in_valid && ready_q;
    assign frame_start    = bclk_fall && (bit_cnt == CNT_W'(FRAME_BITS - 1));
    assign bit_cnt_nxt    = frame_start ? '0 : bit_cnt + CNT_W'(1);

    // A frame-start load always takes the old hold content; a same-cycle
    // transfer then refills hold for the following frame.
    always_comb begin
        frame_nxt     = frame_q;
        hold_full_nxt = hold_full || accept;
        if (frame_start) begin
            frame_nxt     = hold_full ? hold_q : '0;
            hold_full_nxt = accept;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_cnt   <= '0;
            hold_q    <= '0;
            frame_q   <= '0;
            ready_q   <= 1'b1;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= frame_start && !hold_full;
            ready_q  <= !hold_full_nxt;
            if (accept) begin
                hold_q <= in_if.in_sample;
            end
            if (bclk_fall) begin
                bit_cnt   <= bit_cnt_nxt;
                frame_q   <= frame_nxt;
                i2s_lrclk <= (bit_cnt_nxt >= CNT_W'(SLOT_W));
                i2s_sdata <= slot_bit(frame_nxt, bit_cnt_nxt);
            end
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter at CLK_DIV=2, SLOT_W=32 (256 clk per frame).
module tb_i2s_transmitter;
    import eq_pkg::*;

    localparam int CLK_DIV  = 2;
    localparam int SLOT_W   = 32;
    localparam int BCLK_CYC = 2 * CLK_DIV;
    localparam int FRAME_E  = BCLK_CYC * 2 * SLOT_W;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic i2s_bclk;
    logic i2s_lrclk;
    logic i2s_sdata;
    logic underrun;

    int vec_cnt = 0;
    int err_cnt = 0;

    i2s_transmitter_if #(.SAMPLE_W(AUDIO_SAMPLE_W)) bus ();

    i2s_transmitter #(
        .SAMPLE_W (AUDIO_SAMPLE_W),
        .SLOT_W   (SLOT_W),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_if     (bus),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_sdata (i2s_sdata),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected serial bit k (0..63) of a frame carrying sample s.
    function automatic logic exp_bit(input logic [15:0] s, input int k);
        int          p;
        logic [15:0] t;
        p = k % SLOT_W;
`ifdef I2S_LEFT_JUSTIFIED_EN
        if (p <= 15) begin
            t = s >> (15 - p);
            return t[0];
        end
`else
        if (p >= 1 && p <= 16) begin
            t = s >> (16 - p);
            return t[0];
        end
`endif
        return 1'b0;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, " bclk"},     i2s_bclk,     1'b0);
        check({tag, " lrclk"},    i2s_lrclk,    1'b0);
        check({tag, " sdata"},    i2s_sdata,    1'b0);
        check({tag, " underrun"}, underrun,     1'b0);
        check({tag, " in_ready"}, bus.in_ready, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        tick();
        check_reset(tag);
        reset = 1'b1;
    endtask

    // Entered #1 after a frame-start edge (or a reset edge); leaves #1 after
    // the next frame-start edge. in_valid is high for edges v_from..v_to;
    // acc is the edge expected to transfer (0 = none).
    task automatic run_frame(input string tag, input logic [15:0] exp_s,
                             input logic exp_ur, input logic rdy0,
                             input int v_from, input int v_to,
                             input logic [15:0] s_first, input logic [15:0] s_rest,
                             input int acc);
        check({tag, " underrun@start"}, underrun,     exp_ur);
        check({tag, " in_ready@start"}, bus.in_ready, rdy0);
        check({tag, " bit0 sdata"},     i2s_sdata,    exp_bit(exp_s, 0));
        check({tag, " bit0 lrclk"},     i2s_lrclk,    1'b0);
        check({tag, " bit0 bclk"},      i2s_bclk,     1'b0);
        for (int e = 1; e <= FRAME_E; e++) begin
            bus.in_valid  = (e >= v_from) && (e <= v_to);
            bus.in_sample = (e == v_from) ? s_first :
                            (bus.in_valid ? s_rest : (16'hDEAD ^ 16'(e)));
            tick();
            if (e == 1)
                check({tag, " underrun@start+1"}, underrun, 1'b0);
            if (e == acc)
                check($sformatf("%s in_ready after transfer e%0d", tag, e), bus.in_ready, 1'b0);
            if (e % BCLK_CYC == CLK_DIV)
                check($sformatf("%s bclk high e%0d", tag, e), i2s_bclk, 1'b1);
            if (e % BCLK_CYC == 0 && e < FRAME_E) begin
                check($sformatf("%s bit%0d sdata", tag, e / BCLK_CYC), i2s_sdata,
                      exp_bit(exp_s, e / BCLK_CYC));
                check($sformatf("%s bit%0d lrclk", tag, e / BCLK_CYC), i2s_lrclk,
                      logic'((e / BCLK_CYC) >= SLOT_W));
                check($sformatf("%s bit%0d bclk", tag, e / BCLK_CYC), i2s_bclk, 1'b0);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;

        // Single push of 0xA5C3: silent startup frame, then the sample in both slots.
        do_reset("t1 reset");
        run_frame("t1 startup", 16'h0000, 1'b0, 1'b1, 1, 1, 16'hA5C3, 16'h0000, 1);
        run_frame("t1 A5C3",    16'hA5C3, 1'b0, 1'b1, 0, 0, 16'h0000, 16'h0000, 0);

        // No input: quiet startup frame, then an underrun pulse at each frame start.
        do_reset("t2 reset");
        run_frame("t2 startup", 16'h0000, 1'b0, 1'b1, 0, 0, 16'h0000, 16'h0000, 0);
        run_frame("t2 empty1",  16'h0000, 1'b1, 1'b1, 0, 0, 16'h0000, 16'h0000, 0);
        run_frame("t2 empty2",  16'h0000, 1'b1, 1'b1, 0, 0, 16'h0000, 16'h0000, 0);

        // Back-to-back 0x0001 / 0x8000 with in_valid held high.
        do_reset("t3 reset");
        run_frame("t3 startup", 16'h0000, 1'b0, 1'b1, 1, FRAME_E, 16'h0001, 16'h8000, 1);
        run_frame("t3 0001",    16'h0001, 1'b0, 1'b1, 1, 1, 16'h8000, 16'h0000, 1);
        // 0x7FFF transferred on the very edge that starts the next frame, hold empty.
        run_frame("t3 8000",    16'h8000, 1'b0, 1'b1, FRAME_E, FRAME_E, 16'h7FFF, 16'h0000, FRAME_E);
        run_frame("t4 underrun", 16'h0000, 1'b1, 1'b0, 0, 0, 16'h0000, 16'h0000, 0);
        run_frame("t4 7FFF",    16'h7FFF, 1'b0, 1'b1, 0, 0, 16'h0000, 16'h0000, 0);

        // Reset in the middle of the right slot while a sample is buffered.
        do_reset("t5 reset");
        bus.in_valid  = 1'b1;
        bus.in_sample = 16'h1357;
        tick();
        bus.in_valid  = 1'b0;
        check("t5 in_ready after push", bus.in_ready, 1'b0);
        repeat (149) tick();
        check("t5 mid right lrclk",    i2s_lrclk,    1'b1);
        check("t5 mid right bclk",     i2s_bclk,     1'b1);
        check("t5 mid right in_ready", bus.in_ready, 1'b0);
        reset = 1'b0;
        tick();
        check_reset("t5 abort");
        reset = 1'b1;
        run_frame("t5 startup", 16'h0000, 1'b0, 1'b1, 0, 0, 16'h0000, 16'h0000, 0);
        run_frame("t5 dropped", 16'h0000, 1'b1, 1'b1, 0, 0, 16'h0000, 16'h0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Serialises the equalizer's processed mono samples (`audio_out`, signed 16-bit) onto an I2S link to the external DAC.
- Accepts parallel samples through a valid/ready handshake and buffers one sample.
- Generates BCLK and LRCLK from the system clock.
- Transmits each sample on both left and right slots of one frame.

Parameters:
- SAMPLE_W, 16, sample width in bits.
- SLOT_W, 32, BCLK periods per channel slot; must be >= SAMPLE_W+1.
- CLK_DIV, 4, clk cycles per BCLK half-period; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- in_sample  input  SAMPLE_W  signed sample from the equalizer.
- in_valid  input  1  in_sample is valid.
- in_ready  output  1  holding register empty; the sample can be accepted.
- i2s_bclk  output  1  bit clock.
- i2s_lrclk  output  1  word select; 0 = left, 1 = right.
- i2s_sdata  output  1  serial data, MSB first.
- underrun  output  1  one-clk pulse when a frame starts with no sample buffered.

Behaviour:
- Reset (reset==0 at a clk edge):
  - div_cnt=0, bit_cnt=0.
  - i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, underrun=0.
  - Holding register empty, so in_ready=1. Frame register=0.
  - Reset asserted mid-frame aborts the frame immediately; no partial flush.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - i2s_bclk toggles on the cycle div_cnt==CLK_DIV-1.
  - BCLK period = 2*CLK_DIV clk cycles.
- Falling event: the cycle in which i2s_bclk toggles 1→0. On this same edge the following registered outputs update:
  - bit_cnt increments modulo 2*SLOT_W.
  - i2s_lrclk = (new bit_cnt >= SLOT_W).
  - i2s_sdata = data bit for the new bit_cnt.
- Data mapping, with p = bit_cnt mod SLOT_W (I2S format):
  - p==0 → 0.
  - p in 1..SAMPLE_W → frame[SAMPLE_W-p].
  - p > SAMPLE_W → 0.
  - Left and right slots carry the identical sample.
- Frame start: the falling event on which bit_cnt wraps 2*SLOT_W-1 → 0.
  - If the holding register is full: frame register ← hold, hold becomes empty.
  - Otherwise: frame register ← 0 and underrun pulses high for exactly that clk cycle.
- Startup frame: the first frame after reset transmits the reset frame register (zeros) and does not raise underrun.
- Handshake:
  - Transfer occurs when in_valid && in_ready at a clk edge.
  - in_ready is registered and equals !hold_full.
  - If a transfer and a frame start occur in the same cycle, the frame-start load takes the old hold content. The new sample then occupies hold and in_ready stays 0.
  - If hold is empty at that frame start, the frame sends zeros with underrun. The incoming sample is kept for the next frame.
  - in_sample is never sampled when in_ready==0.
- Latency: an accepted sample is transmitted in the first frame whose start is strictly after the acceptance cycle. Its MSB appears on i2s_sdata one BCLK period after the i2s_lrclk falling edge.
- Throughput: one sample per frame (2*SLOT_W*2*CLK_DIV clk cycles).

Optional Feature:
- Macro: I2S_LEFT_JUSTIFIED_EN.
- Defined: left-justified format.
  - p in 0..SAMPLE_W-1 → frame[SAMPLE_W-1-p]; others → 0.
  - MSB is coincident with the lrclk edge. The SLOT_W >= SAMPLE_W constraint relaxes.
- Undefined: standard I2S one-bit delay as above.
- Handshake, underrun and timing are identical in both builds.

Decomposition:
- Package eq_pkg:
  - AUDIO_SAMPLE_W=16.
  - I2S_SLOT_W_DEFAULT=32.
  - typedef audio_sample_t (logic signed [15:0]).
- Sub-module i2s_clk_gen: the divider. Outputs i2s_bclk plus a one-cycle bclk_fall strobe, which the serialiser consumes.

Test Plan:
1. CLK_DIV=2, SLOT_W=32. Reset then push 0xA5C3 once. → After the startup frame, left slot sdata = 0, then 1010010111000011, then 15 zeros. Right slot is identical. lrclk toggles every 128 clk.
2. No input after reset. → Startup frame is all zeros with underrun=0. Every subsequent frame is all zeros, with a single-cycle underrun pulse at each frame start.
3. in_valid held high with 0x0001, 0x8000 back-to-back. → First accepted at cycle 1 and in_ready drops. Second accepted only on the cycle after the next frame start. Frames carry 0x0001 then 0x8000 with no underrun.
4. Transfer of 0x7FFF coincident with a frame start while hold is empty. → That frame is zeros with underrun=1. The next frame carries 0x7FFF.
5. Assert reset mid-right-slot with hold full. → Next cycle all outputs are at reset values and in_ready=1. The buffered sample is never transmitted.
6. Build with I2S_LEFT_JUSTIFIED_EN, push 0xA5C3. → The MSB bit appears on the same falling event as the lrclk change, and bits 16..31 of each slot are zero.
